// File: rtl/timer_scheduler.sv
// Purpose: shares one memory-mapped period timer between N_CH requesters using round-robin arbitration.
// Latency: req in IDLE -> timer load write 2 cycles; END seen in RUN -> done pulse 2 cycles; period 0 -> done 2 cycles after req.
// Backpressure: requests are level-held and wait while busy; a withdrawn request aborts the service with a clear write.
module timer_scheduler #(
    parameter int          N_CH    = 4,
    parameter int          CH_W    = 2,
    parameter logic [31:0] TIMEOUT = 32'd400_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     req,
    input  logic [4*N_CH-1:0]   period_in,
    output logic [N_CH-1:0]     done,
    output logic [N_CH-1:0]     err,
    output logic                busy,
    output logic [CH_W-1:0]     cur_ch,
    output logic                timer_we,
    output logic [31:0]         timer_wdata,
    input  logic [31:0]         timer_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_CLEAR,
        S_DONE
    } state_t;

    // How the current service ended; decides which pulse DONE emits.
    typedef enum logic [1:0] {
        F_DONE,
        F_ERR,
        F_ABORT
    } flag_t;

    // Channel index arithmetic modulo N_CH (N_CH need not be a power of two).
    function automatic logic [CH_W-1:0] f_wrap(input int v);
        int m;
        m = v % N_CH;
        return m[CH_W-1:0];
    endfunction

    state_t             r_state;
    logic [CH_W-1:0]    r_cur_ch;
    logic [3:0]         r_period;
    flag_t              r_flag;
    logic [CH_W-1:0]    r_ptr;
    logic [31:0]        r_wdog;
    logic [N_CH-1:0]    r_done;
    logic [N_CH-1:0]    r_err;
    logic               r_busy;
    logic               r_we;
    logic [31:0]        r_wdata;

    state_t             w_state_nxt;
    logic [CH_W-1:0]    w_cur_ch_nxt;
    logic [3:0]         w_period_nxt;
    flag_t              w_flag_nxt;
    logic [CH_W-1:0]    w_ptr_nxt;
    logic [31:0]        w_wdog_nxt;
    logic [N_CH-1:0]    w_done_nxt;
    logic [N_CH-1:0]    w_err_nxt;
    logic               w_busy_nxt;
    logic               w_we_nxt;
    logic [31:0]        w_wdata_nxt;

    logic [CH_W-1:0]    w_win;
    logic               w_win_vld;
    logic [3:0]         w_win_period;
    logic               w_wdog_hit;
    logic               w_end;
    logic               w_unused_rdata;

    // Only END is meaningful here; the period field read back is not needed.
    assign w_end          = timer_rdata[4];
    assign w_unused_rdata = ^{timer_rdata[31:5], timer_rdata[3:0]};

    // A zero TIMEOUT turns the watchdog off entirely.
    assign w_wdog_hit = (TIMEOUT != 32'd0) && (r_wdog == (TIMEOUT - 32'd1));

    // Round-robin search: first requesting channel at or after the pointer, wrapping.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_win_vld && req[f_wrap(int'(r_ptr) + i)]) begin
                w_win_vld = 1'b1;
                w_win     = f_wrap(int'(r_ptr) + i);
            end
        end
    end

    assign w_win_period = period_in[4*int'(w_win) +: 4];

    // Next-state and next-value logic for the service sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_ch_nxt = r_cur_ch;
        w_period_nxt = r_period;
        w_flag_nxt   = r_flag;
        w_ptr_nxt    = r_ptr;
        w_wdog_nxt   = r_wdog;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (!w_win_vld) begin
                    // Everyone withdrew between IDLE and ARB.
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cur_ch_nxt = w_win;
                    w_period_nxt = w_win_period;
                    if (w_win_period == 4'd0) begin
                        // Zero delay: complete without touching the timer.
                        w_flag_nxt  = F_DONE;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                // Skip one cycle so an END left over from the old value is never seen.
                w_wdog_nxt  = 32'd0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_wdog_nxt = r_wdog + 32'd1;
                if (!req[r_cur_ch]) begin
                    w_flag_nxt  = F_ABORT;
                    w_state_nxt = S_CLEAR;
                end else if (w_end) begin
                    w_flag_nxt  = F_DONE;
                    w_state_nxt = S_CLEAR;
                end else if (w_wdog_hit) begin
                    w_flag_nxt  = F_ERR;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_ptr_nxt   = f_wrap(int'(r_cur_ch) + 1);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the state being entered, so every output is a flop.
    always_comb begin
        w_done_nxt  = '0;
        w_err_nxt   = '0;
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_we_nxt    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_CLEAR);
        w_wdata_nxt = 32'd0;
        if (w_state_nxt == S_LOAD) begin
            w_wdata_nxt = {27'b0, 1'b0, w_period_nxt};
        end
        if (w_state_nxt == S_DONE) begin
            if (w_flag_nxt == F_DONE) begin
                w_done_nxt[w_cur_ch_nxt] = 1'b1;
            end else if (w_flag_nxt == F_ERR) begin
                w_err_nxt[w_cur_ch_nxt] = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any service without a clear write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cur_ch <= '0;
            r_period <= 4'd0;
            r_flag   <= F_DONE;
            r_ptr    <= '0;
            r_wdog   <= 32'd0;
            r_done   <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
            r_we     <= 1'b0;
            r_wdata  <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_ch <= w_cur_ch_nxt;
            r_period <= w_period_nxt;
            r_flag   <= w_flag_nxt;
            r_ptr    <= w_ptr_nxt;
            r_wdog   <= w_wdog_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            r_we     <= w_we_nxt;
            r_wdata  <= w_wdata_nxt;
        end
    end

    assign done        = r_done;
    assign err         = r_err;
    assign busy        = r_busy;
    assign cur_ch      = r_cur_ch;
    assign timer_we    = r_we;
    assign timer_wdata = r_wdata;

endmodule

// File: tb/tb_timer_scheduler.sv
// Purpose: self-checking bench for timer_scheduler with a behavioural timer register model.
// Latency: table rows check outputs one edge after each input vector; sequences check multi-cycle behaviour.
// Backpressure: requesters drop req in the cycle their done/err pulse is seen.
module tb_timer_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] period_in;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    logic [1:0]  cur_ch;
    logic        timer_we;
    logic [31:0] timer_wdata;
    logic [31:0] timer_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit          model_en = 1'b0;
    bit          end_en   = 1'b1;
    logic [31:0] tbl_rd   = 32'h0;
    logic [31:0] mdl_reg  = 32'h0;
    int          mdl_cnt  = 0;

    logic [31:0] we_q[$];
    int          wecyc_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;

    timer_scheduler #(.N_CH(4), .CH_W(2), .TIMEOUT(32'd20)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .period_in   (period_in),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .cur_ch      (cur_ch),
        .timer_we    (timer_we),
        .timer_wdata (timer_wdata),
        .timer_rdata (timer_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timer register model: a write loads it, then END rises after 'period' ticks (1 tick per clock).
    always @(negedge clk) begin
        if (timer_we) begin
            mdl_reg = timer_wdata;
            mdl_cnt = 0;
        end else if (end_en && mdl_reg[3:0] != 4'd0 && !mdl_reg[4]) begin
            mdl_cnt++;
            if (mdl_cnt >= int'(mdl_reg[3:0])) mdl_reg[4] = 1'b1;
        end
    end

    assign timer_rdata = model_en ? mdl_reg : tbl_rd;

    // Log every timer write and count pulses.
    always @(negedge clk) begin
        if (timer_we) begin
            we_q.push_back(timer_wdata);
            wecyc_q.push_back(cyc);
        end
        done_cnt += $countones(done);
        err_cnt  += $countones(err);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // Wait (bounded) for a done/err pulse; the served requester drops its req at once.
    task automatic wait_pulse(output int ch, output bit is_err, output int at_cyc);
        bit got;
        got    = 1'b0;
        ch     = -1;
        is_err = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if ((done | err) != 4'd0) begin
                got = 1'b1;
                for (int c = 0; c < 4; c++) if (done[c] || err[c]) ch = c;
                is_err = |err;
                at_cyc = cyc;
                req    = req & ~(done | err);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_pulse: got=no pulse want=pulse within 200 cycles");
        end
    endtask

    typedef struct packed {
        logic        busy;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  dn;
        logic [3:0]  er;
        logic [1:0]  ch;
    } out_t;

    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] per;
        logic [31:0] rd;
        out_t        o;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] rd, input logic b,
                                input logic w, input logic [31:0] wd, input logic [3:0] dn);
        vec_t v;
        v.req  = r;
        v.per  = 16'h0003;
        v.rd   = rd;
        v.o.busy = b;
        v.o.we   = w;
        v.o.wd   = wd;
        v.o.dn   = dn;
        v.o.er   = 4'h0;
        v.o.ch   = 2'd0;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        int   ch;
        bit   e;
        int   c;
        int   d0;
        out_t got;

        #200000;
        $display("FAIL global_timeout: got=stuck want=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   ch;
        bit   e;
        int   c;
        int   d0;
        out_t got;

        // Single channel, period 3; rdata driven from the table. Stale END (0x10) before RUN must be ignored.
        tbl[0] = mk(4'b0001, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0); // -> ARB
        tbl[1] = mk(4'b0001, 32'h10, 1'b1, 1'b1, 32'h3, 4'h0); // -> LOAD
        tbl[2] = mk(4'b0001, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0); // -> SETTLE
        tbl[3] = mk(4'b0001, 32'h10, 1'b1, 1'b0, 32'h0, 4'h0); // -> RUN
        tbl[4] = mk(4'b0001, 32'h03, 1'b1, 1'b0, 32'h0, 4'h0); // RUN, no END
        tbl[5] = mk(4'b0001, 32'h13, 1'b1, 1'b1, 32'h0, 4'h0); // END -> CLEAR
        tbl[6] = mk(4'b0001, 32'h13, 1'b1, 1'b0, 32'h0, 4'h1); // -> DONE, done[0]
        tbl[7] = mk(4'b0000, 32'h00, 1'b0, 1'b0, 32'h0, 4'h0); // -> IDLE

        rst       = 1'b1;
        req       = 4'h0;
        period_in = 16'h0;
        @(posedge clk);
        #1;
        got = {busy, timer_we, timer_wdata, done, err, cur_ch};
        chk("reset_outputs", 64'(got), 64'(out_t'(0)));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req       = tbl[i].req;
            period_in = tbl[i].per;
            tbl_rd    = tbl[i].rd;
            @(posedge clk);
            #1;
            got = {busy, timer_we, timer_wdata, done, err, cur_ch};
            chk($sformatf("table_row%0d", i), 64'(got), 64'(tbl[i].o));
        end

        // Contention: ch1 and ch3 with period 1; pointer now 1.
        model_en = 1'b1;
        @(negedge clk);
        we_q.delete();
        wecyc_q.delete();
        period_in = 16'h1010;
        req       = 4'b1010;
        wait_pulse(ch, e, c);
        chk("cont_first_ch", 64'(ch), 64'd1);
        chk("cont_first_is_err", 64'(e), 64'd0);
        @(negedge clk);
        req[1] = 1'b1;
        wait_pulse(ch, e, c);
        chk("cont_second_ch", 64'(ch), 64'd3);
        wait_pulse(ch, e, c);
        chk("cont_third_ch", 64'(ch), 64'd1);
        chk("cont_we_count", 64'(we_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < we_q.size(); i++)
            chk($sformatf("cont_wdata%0d", i), 64'(we_q[i]), (i % 2 == 0) ? 64'h1 : 64'h0);

        // Period 0 on ch2: no timer write; done two cycles after req is seen in IDLE.
        @(negedge clk);
        we_q.delete();
        wecyc_q.delete();
        period_in = 16'h0000;
        req       = 4'b0100;
        @(negedge clk);
        chk("p0_arb_busy_done", 64'({busy, done}), 64'({1'b1, 4'h0}));
        @(negedge clk);
        chk("p0_done", 64'(done), 64'h4);
        req = 4'b0000;
        @(negedge clk);
        chk("p0_idle_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("p0_no_timer_we", 64'(we_q.size()), 64'd0);

        // Abort: ch0 period 15 withdrawn in RUN; ch1 (period 2) served next.
        we_q.delete();
        wecyc_q.delete();
        period_in = 16'h002F;
        req       = 4'b0011;
        repeat (5) @(negedge clk);
        chk("abort_cur_ch", 64'({busy, cur_ch}), 64'({1'b1, 2'd0}));
        req[0] = 1'b0;
        wait_pulse(ch, e, c);
        chk("abort_next_ch", 64'(ch), 64'd1);
        chk("abort_next_is_err", 64'(e), 64'd0);
        chk("abort_we_count", 64'(we_q.size()), 64'd4);
        if (we_q.size() == 4)
            chk("abort_wdata_seq", {we_q[0][15:0], we_q[1][15:0], we_q[2][15:0], we_q[3][15:0]},
                64'h000F_0000_0002_0000);

        // Watchdog: END never rises, TIMEOUT=20 -> err[0] one cycle after the clear write.
        @(negedge clk);
        end_en = 1'b0;
        we_q.delete();
        wecyc_q.delete();
        d0        = done_cnt;
        period_in = 16'h0005;
        req       = 4'b0001;
        wait_pulse(ch, e, c);
        chk("wdog_ch", 64'(ch), 64'd0);
        chk("wdog_is_err", 64'(e), 64'd1);
        chk("wdog_no_done", 64'(done_cnt), 64'(d0));
        chk("wdog_we_count", 64'(we_q.size()), 64'd2);
        if (wecyc_q.size() == 2) begin
            chk("wdog_load_to_err", 64'(c - wecyc_q[0]), 64'd23);
            chk("wdog_clear_to_err", 64'(c - wecyc_q[1]), 64'd1);
            chk("wdog_wdata_seq", {we_q[0], we_q[1]}, {32'h5, 32'h0});
        end
        end_en = 1'b1;

        // Reset mid-RUN on ch3 (pointer 1); held req must restart from pointer 0 -> ch0 first.
        @(negedge clk);
        period_in = 16'h5002;
        req       = 4'b1001;
        repeat (5) @(negedge clk);
        chk("rst_pre_cur_ch", 64'({busy, cur_ch}), 64'({1'b1, 2'd3}));
        rst = 1'b1;
        @(negedge clk);
        got = {busy, timer_we, timer_wdata, done, err, cur_ch};
        chk("rst_midrun_outputs", 64'(got), 64'(out_t'(0)));
        rst = 1'b0;
        wait_pulse(ch, e, c);
        chk("rst_restart_ch", 64'(ch), 64'd0);
        wait_pulse(ch, e, c);
        chk("rst_then_ch", 64'(ch), 64'd3);

        repeat (3) @(negedge clk);
        chk("total_done_pulses", 64'(done_cnt), 64'd8);
        chk("total_err_pulses", 64'(err_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
